param_regfile: RTL and testbench

//  Parametrised successor to the 4x32 processor register file: DEPTH x WIDTH storage,
//  1 write port, 2 combinational read ports with write-to-read bypass, per-register

---
 rtl/param_regfile_if.sv | 34 +++
 rtl/param_regfile.sv | 135 +++++++++++++
 tb/tb_param_regfile.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/param_regfile_if.sv
// param_regfile_if: bus bundle between the decode stage / ALU operand muxes and the
// register file.
//   Write port : wr_en, wr_addr, wr_data (master -> slave), wr_ready (slave -> master)
//   Read ports : src1, src2 (master -> slave); data_out1/2, valid1/2 (slave -> master)
//   Clear      : clr_req (master -> slave); clr_busy, clr_done (slave -> master)
// Parameters WIDTH and ADDR_W must match the attached param_regfile instance.
interface param_regfile_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              wr_ready;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic [WIDTH-1:0]  data_out1;
    logic [WIDTH-1:0]  data_out2;
    logic              valid1;
    logic              valid2;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    modport master (
        output wr_en, wr_addr, wr_data, src1, src2, clr_req,
        input  wr_ready, data_out1, data_out2, valid1, valid2, clr_busy, clr_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, src1, src2, clr_req,
        output wr_ready, data_out1, data_out2, valid1, valid2, clr_busy, clr_done
    );
endinterface

// File: rtl/param_regfile.sv
// param_regfile: DEPTH x WIDTH register file with one write port, two combinational
// read ports with write-to-read bypass, per-register written flags and a sequenced
// hardware clear (one register per cycle, busy/done handshake).
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - asynchronous active-low reset
//   bus    - param_regfile_if.slave (write port, two read ports, clear handshake)
// Optional feature: define REGFILE_ZERO_REG_EN to hardwire register 0 to zero
// (reads of index 0 return 0 with valid=1, writes to index 0 are accepted but dropped).
module param_regfile #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    param_regfile_if.slave bus
);
    // Array index width; out-of-range addresses are filtered before slicing.
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] count_q;
    logic              clr_done_q;
    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [DEPTH-1:0]  flag_q;

    logic [IdxW-1:0]   wr_idx, src1_idx, src2_idx, clr_idx;
    logic              wr_in_range, src1_in_range, src2_in_range;
    logic              wr_zero, src1_zero, src2_zero;
    logic              wr_commit, clr_last;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    assign wr_idx   = bus.wr_addr[IdxW-1:0];
    assign src1_idx = bus.src1[IdxW-1:0];
    assign src2_idx = bus.src2[IdxW-1:0];
    assign clr_idx  = count_q[IdxW-1:0];

    assign wr_in_range   = in_range(bus.wr_addr);
    assign src1_in_range = in_range(bus.src1);
    assign src2_in_range = in_range(bus.src2);

`ifdef REGFILE_ZERO_REG_EN
    assign wr_zero   = (bus.wr_addr == '0);
    assign src1_zero = (bus.src1 == '0);
    assign src2_zero = (bus.src2 == '0);
`else
    assign wr_zero   = 1'b0;
    assign src1_zero = 1'b0;
    assign src2_zero = 1'b0;
`endif

    // A write to hardwired r0 is handshaken normally but never reaches the array.
    assign wr_commit = bus.wr_en && (state_q == StIdle) && wr_in_range && !wr_zero;
    assign clr_last  = (32'(count_q) == DEPTH - 1);

    assign bus.wr_ready = (state_q == StIdle);
    assign bus.clr_busy = (state_q == StClear);
    assign bus.clr_done = clr_done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            clr_done_q <= 1'b0;
            flag_q     <= '0;
            regs_q     <= '{default: '0};
        end else begin
            clr_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (wr_commit) begin
                        regs_q[wr_idx] <= bus.wr_data;
                        flag_q[wr_idx] <= 1'b1;
                    end
                    if (bus.clr_req) begin
                        state_q <= StClear;
                        count_q <= '0;
                    end
                end
                StClear: begin
                    // clr_req is ignored here: a clear in progress never restarts.
                    regs_q[clr_idx] <= '0;
                    flag_q[clr_idx] <= 1'b0;
                    if (clr_last) begin
                        state_q    <= StIdle;
                        clr_done_q <= 1'b1;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Read port 1: hardwired zero, then bypass of a committing write, then array.
    always_comb begin
        bus.data_out1 = '0;
        bus.valid1    = 1'b0;
        if (src1_in_range) begin
            if (src1_zero) begin
                bus.valid1 = 1'b1;
            end else if (wr_commit && (bus.wr_addr == bus.src1)) begin
                bus.data_out1 = bus.wr_data;
                bus.valid1    = 1'b1;
            end else begin
                bus.data_out1 = regs_q[src1_idx];
                bus.valid1    = flag_q[src1_idx];
            end
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        bus.data_out2 = '0;
        bus.valid2    = 1'b0;
        if (src2_in_range) begin
            if (src2_zero) begin
                bus.valid2 = 1'b1;
            end else if (wr_commit && (bus.wr_addr == bus.src2)) begin
                bus.data_out2 = bus.wr_data;
                bus.valid2    = 1'b1;
            end else begin
                bus.data_out2 = regs_q[src2_idx];
                bus.valid2    = flag_q[src2_idx];
            end
        end
    end
endmodule

// File: tb/tb_param_regfile.sv
// tb_param_regfile: directed self-checking bench for param_regfile (WIDTH=32, DEPTH=8,
// ADDR_W=5). Expected values for register 0 follow REGFILE_ZERO_REG_EN when defined.
module tb_param_regfile;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 5;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZeroReg = 1'b1;
`else
    localparam bit ZeroReg = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    param_regfile_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    param_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen_done;
        logic [31:0] exp_d;

        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.src1 = 5'd3; bus.src2 = 5'd4; bus.clr_req = 1'b0;
        #3;
        check("rst_wr_ready", bus.wr_ready, 1);
        check("rst_clr_busy", bus.clr_busy, 0);
        check("rst_clr_done", bus.clr_done, 0);
        check("rst_data1", bus.data_out1, 0);
        check("rst_valid1", bus.valid1, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // 1: write r3, read it back next cycle; r4 untouched
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'hDEADBEEF;
        tick();
        bus.wr_en = 1'b0; bus.src1 = 5'd3; bus.src2 = 5'd4;
        #1;
        check("t1_data1", bus.data_out1, 32'hDEADBEEF);
        check("t1_valid1", bus.valid1, 1);
        check("t1_data2", bus.data_out2, 0);
        check("t1_valid2", bus.valid2, 0);

        // 2: bypass on both ports, then registered value
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'h12345678;
        bus.src1 = 5'd5; bus.src2 = 5'd5;
        #1;
        check("t2_byp_data1", bus.data_out1, 32'h12345678);
        check("t2_byp_data2", bus.data_out2, 32'h12345678);
        check("t2_byp_valid1", bus.valid1, 1);
        check("t2_byp_valid2", bus.valid2, 1);
        tick();
        bus.wr_en = 1'b0;
        #1;
        check("t2_reg_data1", bus.data_out1, 32'h12345678);
        check("t2_reg_valid1", bus.valid1, 1);

        // 3: fill all, clear, expect 8 busy cycles and a 1-cycle done pulse
        for (int i = 0; i < 8; i++) begin
            bus.wr_en = 1'b1; bus.wr_addr = 5'(i); bus.wr_data = 32'h11 * (i + 1);
            tick();
        end
        bus.wr_en = 1'b0; bus.src1 = 5'd0; bus.src2 = 5'd7;
        #1;
        check("t3_r0", bus.data_out1, ZeroReg ? 32'h0 : 32'h11);
        check("t3_r7", bus.data_out2, 32'h88);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        check("t3_wr_ready_clr", bus.wr_ready, 0);
        n = 0;
        while (bus.clr_busy && n < 20) begin
            n++;
            tick();
        end
        check("t3_busy_cycles", n, 8);
        check("t3_done_hi", bus.clr_done, 1);
        check("t3_wr_ready_idle", bus.wr_ready, 1);
        tick();
        check("t3_done_lo", bus.clr_done, 0);
        for (int i = 0; i < 8; i++) begin
            bus.src1 = 5'(i);
            #1;
            check($sformatf("t3_clr_data_r%0d", i), bus.data_out1, 0);
            check($sformatf("t3_clr_valid_r%0d", i), bus.valid1, (i == 0) ? ZeroReg : 1'b0);
        end

        // 4: write held across CLEAR, second clr_req ignored
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 32'hCAFE; bus.src1 = 5'd2;
        #1;
        check("t4_no_ready", bus.wr_ready, 0);
        check("t4_no_bypass", bus.data_out1, 0);
        check("t4_no_bypass_v", bus.valid1, 0);
        n = 0;
        while (bus.clr_busy && n < 20) begin
            bus.clr_req = (n == 3);
            tick();
            n++;
        end
        bus.clr_req = 1'b0;
        check("t4_busy_cycles", n, 8);
        #1;
        check("t4_idle_bypass", bus.data_out1, 32'hCAFE);
        tick();
        bus.wr_en = 1'b0;
        #1;
        check("t4_r2", bus.data_out1, 32'hCAFE);
        check("t4_r2_valid", bus.valid1, 1);
        check("t4_no_restart", bus.clr_busy, 0);

        // 5: reset at count 3 aborts the clear with no done pulse
        bus.wr_en = 1'b1; bus.wr_addr = 5'd6; bus.wr_data = 32'hA5A5A5A5;
        tick();
        bus.wr_en = 1'b0;
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        tick(); tick(); tick();
        bus.src1 = 5'd6;
        #1;
        check("t5_pre_r6", bus.data_out1, 32'hA5A5A5A5);
        reset = 1'b0;
        #1;
        check("t5_busy", bus.clr_busy, 0);
        check("t5_ready", bus.wr_ready, 1);
        check("t5_r6", bus.data_out1, 0);
        check("t5_r6_valid", bus.valid1, 0);
        @(negedge clk);
        reset = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.clr_done || bus.clr_busy) seen_done = 1'b1;
        end
        check("t5_no_done", seen_done, 0);

        // 6: out-of-range index, then r0 behaviour
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h55; bus.src1 = 5'd9;
        #1;
        check("t6_oor_data", bus.data_out1, 0);
        check("t6_oor_valid", bus.valid1, 0);
        tick();
        bus.wr_en = 1'b0; bus.src1 = 5'd1;
        #1;
        check("t6_alias_r1", bus.data_out1, 0);
        check("t6_alias_r1_v", bus.valid1, 0);
        exp_d = ZeroReg ? 32'h0 : 32'hFFFF;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFF; bus.src1 = 5'd0;
        #1;
        check("t6_r0_ready", bus.wr_ready, 1);
        check("t6_r0_byp", bus.data_out1, exp_d);
        check("t6_r0_byp_v", bus.valid1, 1);
        tick();
        bus.wr_en = 1'b0;
        #1;
        check("t6_r0_reg", bus.data_out1, exp_d);
        check("t6_r0_reg_v", bus.valid1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
